// File: rtl/instr_fetch_unit.sv
// Fetch stage for the multi-cycle MIPS32 core: owns the PC, runs the imem req/ack handshake,
// latches the instruction and resolves the next PC. Optional invalid-opcode trap: INV_OPC_TRAP_EN.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0040_0000,
  parameter logic [31:0] TRAP_VECTOR = 32'h8000_0180
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        isJmp,
  input  logic        isBeq,
  input  logic        isBne,
  input  logic        invOpcode,
  input  logic        aluZero,
  output logic [31:0] instr,
  output logic [5:0]  opc,
  output logic [5:0]  func,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] retire_count,
  output logic        trap
);

  typedef enum logic [0:0] {
    S_FETCH = 1'b0,
    S_EXEC  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        r_imem_req;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_retire_count;
  logic        r_trap;

  logic        w_fetch_done;
  logic        w_exec_go;
  logic        w_req_next;
  logic        w_instr_valid;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_jmp_target;
  logic [31:0] w_br_offset;
  logic [31:0] w_br_target;
  logic        w_br_taken;
  logic [31:0] w_next_pc;
  logic        w_take_trap;

  // Ack only counts while a request is actually outstanding in FETCH.
  assign w_fetch_done = (r_state == S_FETCH) & r_imem_req & imem_ack;
  assign w_exec_go    = (r_state == S_EXEC) & ~stall;
  assign w_req_next   = ((r_state == S_FETCH) & ~w_fetch_done) | w_exec_go;

  assign w_pc_plus4   = r_pc + 32'd4;
  assign w_jmp_target = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
  assign w_br_offset  = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
  assign w_br_target  = w_pc_plus4 + w_br_offset;
  assign w_br_taken   = (isBeq & aluZero) | (isBne & ~aluZero);

`ifdef INV_OPC_TRAP_EN
  assign w_take_trap = invOpcode;
`else
  logic [32:0] w_unused_trap;
  assign w_unused_trap = {invOpcode, TRAP_VECTOR};
  assign w_take_trap   = 1'b0;
`endif

  // Next-PC selection: jump beats branch, branch beats sequential.
  always_comb begin
    w_next_pc = w_pc_plus4;
    if (isJmp) begin
      w_next_pc = w_jmp_target;
    end else if (w_br_taken) begin
      w_next_pc = w_br_target;
    end else begin
      w_next_pc = w_pc_plus4;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH: begin
        if (w_fetch_done) begin
          w_next_state = S_EXEC;
        end else begin
          w_next_state = S_FETCH;
        end
      end
      S_EXEC: begin
        if (w_exec_go) begin
          w_next_state = S_FETCH;
        end else begin
          w_next_state = S_EXEC;
        end
      end
      default: w_next_state = S_FETCH;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    w_instr_valid = 1'b0;
    case (r_state)
      S_FETCH: w_instr_valid = 1'b0;
      S_EXEC:  w_instr_valid = 1'b1;
      default: w_instr_valid = 1'b0;
    endcase
  end

  // Datapath registers: request, PC, instruction latch, retire counter, trap pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_imem_req     <= 1'b0;
      r_pc           <= RESET_PC;
      r_instr        <= 32'h0000_0000;
      r_retire_count <= 32'h0000_0000;
      r_trap         <= 1'b0;
    end else begin
      r_imem_req <= w_req_next;
      r_trap     <= w_exec_go & w_take_trap;
      if (w_fetch_done) begin
        r_instr <= imem_rdata;
      end
      if (w_exec_go) begin
        r_pc <= w_take_trap ? TRAP_VECTOR : w_next_pc;
        if (!w_take_trap) begin
          r_retire_count <= r_retire_count + 32'd1;
        end
      end
    end
  end

  assign imem_req     = r_imem_req;
  assign imem_addr    = r_pc;
  assign instr        = r_instr;
  assign opc          = r_instr[31:26];
  assign func         = r_instr[5:0];
  assign instr_valid  = w_instr_valid;
  assign pc           = r_pc;
  assign pc_plus4     = w_pc_plus4;
  assign retire_count = r_retire_count;
  assign trap         = r_trap;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the control unit in the multi-cycle MIPS32 SOC core.
- Owns the PC and drives a req/ack handshake to instruction memory.
- Latches the fetched word and presents opc/func to the control unit.
- Consumes isJmp/isBeq/isBne (control unit) and the ALU zero flag to resolve the next PC; counts retired instructions.

Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded on reset
- TRAP_VECTOR, 32'h8000_0180, PC loaded on invalid opcode (only with INV_OPC_TRAP_EN)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- imem_req  output  1  instruction memory request
- imem_addr  output  32  fetch address (equals pc while imem_req high)
- imem_ack  input  1  memory response valid; imem_rdata sampled this cycle
- imem_rdata  input  32  instruction word
- stall  input  1  holds EXEC (e.g. data memory busy)
- isJmp  input  1  jump decoded
- isBeq  input  1  BEQ decoded
- isBne  input  1  BNE decoded
- invOpcode  input  1  invalid opcode/function decoded
- aluZero  input  1  ALU result zero (rs - rt)
- instr  output  32  latched instruction
- opc  output  6  instr[31:26], to control unit
- func  output  6  instr[5:0], to control unit
- instr_valid  output  1  high in EXEC: instr/opc/func are decode-valid
- pc  output  32  address of current instruction
- pc_plus4  output  32  pc + 4
- retire_count  output  32  instructions retired since reset
- trap  output  1  one-cycle pulse on trap (0 when feature off)

Behaviour:
- Reset values: pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, retire_count=0, trap=0, state=FETCH.
- Outputs: opc/func are combinational slices of instr; pc_plus4 = pc + 32'd4, modulo 2^32 (pc=32'hFFFF_FFFC gives 0).
- FETCH:
  - imem_req=1, imem_addr=pc; both held stable until imem_ack.
  - imem_ack may arrive in the first cycle of FETCH.
  - On imem_ack: instr<=imem_rdata, go to EXEC.
- EXEC:
  - instr_valid=1, imem_req=0.
  - If stall=1: hold everything, including the pc update.
  - If stall=0: pc<=next_pc, retire_count<=retire_count+1 (wraps at 2^32), go to FETCH.
- Minimum throughput: 2 cycles per instruction with zero-wait memory.
- next_pc priority:
  1. isJmp: {pc_plus4[31:28], instr[25:0], 2'b00}
  2. (isBeq & aluZero) | (isBne & ~aluZero): pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00}); 32-bit wrap
  3. otherwise: pc_plus4
- Simultaneous isJmp and isBeq/isBne: jump wins.
- No branch delay slot.
- imem_ack while not in FETCH: ignored.
- rst asserted mid-fetch: imem_req=0 the following cycle; a same-cycle imem_ack is discarded; the next fetch starts at RESET_PC.
- rst dominates stall and all control inputs.

Optional Feature:
- Macro: INV_OPC_TRAP_EN
- Defined: in EXEC with stall=0 and invOpcode=1:
  - pc<=TRAP_VECTOR, trap pulses high for one cycle.
  - retire_count does not increment.
  - Overrides jump/branch.
- Not defined:
  - invOpcode is ignored; the instruction retires and next_pc follows the normal rules.
  - trap is tied 0.

Test Plan:
- Reset release, imem_ack same cycle as req, rdata=32'h2008_0005 (addi) -> imem_addr=32'h0040_0000; instr_valid one cycle later; opc=6'h08; pc becomes 32'h0040_0004; retire_count=1.
- imem_ack delayed 3 cycles -> imem_req and imem_addr stable for all 4 cycles; instr captured only on ack.
- Branch at pc=32'h0040_0010, instr=32'h1000_FFFC, isBeq=1, aluZero=1 -> next pc 32'h0040_0004. Same with aluZero=0 -> 32'h0040_0014.
- Jump at pc=32'h0040_0020, instr=32'h0810_0000, isJmp=1 and isBne=1 -> pc=32'h0040_0000. stall=1 for 2 cycles in EXEC -> pc and retire_count held, then update.
- rst asserted while FETCH waits on ack -> req drops next cycle; a late ack is ignored; refetch from 32'h0040_0000; retire_count=0.
- With INV_OPC_TRAP_EN, invOpcode=1 in EXEC -> pc=32'h8000_0180, trap=1 for one cycle, retire_count unchanged. Without the macro -> pc=pc_plus4, trap=0.
